axi_lite_wr_arbiter: RTL and testbench

AXI_LITE_WR_ARBITER -- requirements
Module: axi_lite_wr_arbiter

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/axi_lite_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_axi_lite_wr_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite write arbiter: response codes and arbiter FSM states.
package axi_lite_pkg;

   localparam int unsigned RESP_WIDTH = 2;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_XFER = 2'b01,
      ST_RESP = 2'b10
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after (last_grant+1) mod NUM_REQ.
module rr_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned GRANT_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]     req,
   input  logic [GRANT_WIDTH-1:0] last_grant,
   output logic [GRANT_WIDTH-1:0] grant,
   output logic                   valid
);

   logic [GRANT_WIDTH-1:0] cand;

   // Walk the ring from farthest to nearest so the nearest requester wins last.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = int'(NUM_REQ); k >= 1; k--) begin
         cand = GRANT_WIDTH'((int'(last_grant) + k) % int'(NUM_REQ));
         if (req[cand]) begin
            grant = cand;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_lite_wr_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite write slave among NUM_REQ requesters,
// one complete AW/W/B transaction per grant.
module axi_lite_wr_arbiter
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]      s_awaddr,
   input  logic [NUM_REQ-1:0]                 s_awvalid,
   output logic [NUM_REQ-1:0]                 s_awready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]      s_wdata,
   input  logic [NUM_REQ*STRB_WIDTH-1:0]      s_wstrb,
   input  logic [NUM_REQ-1:0]                 s_wvalid,
   output logic [NUM_REQ-1:0]                 s_wready,
   output logic [NUM_REQ-1:0]                 s_bvalid,
   output logic [NUM_REQ*RESP_WIDTH-1:0]      s_bresp,
   input  logic [NUM_REQ-1:0]                 s_bready,
   output logic [ADDR_WIDTH-1:0]              m_awaddr,
   output logic                               m_awvalid,
   input  logic                               m_awready,
   output logic [DATA_WIDTH-1:0]              m_wdata,
   output logic [STRB_WIDTH-1:0]              m_wstrb,
   output logic                               m_wvalid,
   input  logic                               m_wready,
   input  logic                               m_bvalid,
   input  logic [RESP_WIDTH-1:0]              m_bresp,
   output logic                               m_bready,
   output logic [$clog2(NUM_REQ)-1:0]         grant_id,
   output logic                               busy
);

   localparam int unsigned GW = $clog2(NUM_REQ);

   arb_state_t    state, state_nxt;
   logic [GW-1:0] grant_q, last_grant, arb_grant;
   logic          arb_valid;
   logic          aw_done, w_done;
   logic          aw_hs, w_hs, b_hs;

   rr_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .GRANT_WIDTH (GW)
   ) u_rr (
      .req        (s_awvalid),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .valid      (arb_valid)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; RESP is entered on the edge that completes the second channel
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (arb_valid)                                  state_nxt = ST_XFER;
         ST_XFER: if ((aw_done || aw_hs) && (w_done || w_hs))     state_nxt = ST_RESP;
         ST_RESP: if (b_hs)                                       state_nxt = ST_IDLE;
         default:                                                 state_nxt = ST_IDLE;
      endcase
   end

   // Channel muxing: only the owner is connected, and only in the phase it belongs to
   always_comb begin
      m_awaddr  = '0;
      m_awvalid = 1'b0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      s_awready = '0;
      s_wready  = '0;
      s_bvalid  = '0;
      s_bresp   = '0;
      aw_hs     = 1'b0;
      w_hs      = 1'b0;
      b_hs      = 1'b0;
      case (state)
         ST_XFER: begin
            m_awaddr           = s_awaddr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
            m_awvalid          = s_awvalid[grant_q] & ~aw_done;
            s_awready[grant_q] = m_awready & ~aw_done;
            m_wdata            = s_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            m_wstrb            = s_wstrb[int'(grant_q)*STRB_WIDTH +: STRB_WIDTH];
            m_wvalid           = s_wvalid[grant_q] & ~w_done;
            s_wready[grant_q]  = m_wready & ~w_done;
            aw_hs              = m_awvalid & m_awready;
            w_hs               = m_wvalid & m_wready;
         end
         ST_RESP: begin
            m_bready                                       = s_bready[grant_q];
            s_bvalid[grant_q]                              = m_bvalid;
            s_bresp[int'(grant_q)*RESP_WIDTH +: RESP_WIDTH] = m_bresp;
            b_hs                                           = m_bvalid & s_bready[grant_q];
         end
         default: ;
      endcase
   end

   // Grant, round-robin pointer, per-channel completion flags and busy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q    <= '0;
         last_grant <= GW'(NUM_REQ - 1);
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (arb_valid) begin
               grant_q <= arb_grant;
               busy    <= 1'b1;
            end
            ST_XFER: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
            end
            ST_RESP: if (b_hs) begin
               last_grant <= grant_q;
               aw_done    <= 1'b0;
               w_done     <= 1'b0;
               busy       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign grant_id = grant_q;

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Bench for axi_lite_wr_arbiter: directed vector table plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_axi_lite_wr_arbiter;
   import axi_lite_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned N  = 4;
   localparam int unsigned SW = 4;

   logic              clk, rst;
   logic [N*AW-1:0]   s_awaddr;
   logic [N-1:0]      s_awvalid, s_awready;
   logic [N*DW-1:0]   s_wdata;
   logic [N*SW-1:0]   s_wstrb;
   logic [N-1:0]      s_wvalid, s_wready;
   logic [N-1:0]      s_bvalid, s_bready;
   logic [N*2-1:0]    s_bresp;
   logic [AW-1:0]     m_awaddr;
   logic              m_awvalid, m_awready;
   logic [DW-1:0]     m_wdata;
   logic [SW-1:0]     m_wstrb;
   logic              m_wvalid, m_wready;
   logic              m_bvalid, m_bready;
   logic [1:0]        m_bresp;
   logic [1:0]        grant_id;
   logic              busy;

   axi_lite_wr_arbiter #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_REQ (N), .STRB_WIDTH (SW)
   ) dut (
      .clk (clk), .rst (rst),
      .s_awaddr (s_awaddr), .s_awvalid (s_awvalid), .s_awready (s_awready),
      .s_wdata (s_wdata), .s_wstrb (s_wstrb), .s_wvalid (s_wvalid), .s_wready (s_wready),
      .s_bvalid (s_bvalid), .s_bresp (s_bresp), .s_bready (s_bready),
      .m_awaddr (m_awaddr), .m_awvalid (m_awvalid), .m_awready (m_awready),
      .m_wdata (m_wdata), .m_wstrb (m_wstrb), .m_wvalid (m_wvalid), .m_wready (m_wready),
      .m_bvalid (m_bvalid), .m_bresp (m_bresp), .m_bready (m_bready),
      .grant_id (grant_id), .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  mask;
      logic [1:0]  resp;
      int          aw_dly;
      int          w_dly;
      int          b_dly;
      bit          rst_mid;
      int          exp_g;
      logic [31:0] addr;
      logic [31:0] data;
   } vec_t;

   vec_t        tbl[15];
   int          tests = 0;
   int          fails = 0;
   logic [3:0]  pend_aw, pend_w;
   logic [31:0] ra[4], rd[4];
   logic [3:0]  rs[4];
   int          model_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < 4; i++) begin
         s_awaddr[i*AW +: AW] = ra[i];
         s_wdata[i*DW +: DW]  = rd[i];
         s_wstrb[i*SW +: SW]  = rs[i];
      end
      s_awvalid = pend_aw;
      s_wvalid  = pend_w;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_m_awvalid"}, 64'(m_awvalid), 64'd0);
      check({tag, "_m_wvalid"},  64'(m_wvalid),  64'd0);
      check({tag, "_m_bready"},  64'(m_bready),  64'd0);
      check({tag, "_s_awready"}, 64'(s_awready), 64'd0);
      check({tag, "_s_wready"},  64'(s_wready),  64'd0);
      check({tag, "_s_bvalid"},  64'(s_bvalid),  64'd0);
      check({tag, "_s_bresp"},   64'(s_bresp),   64'd0);
      check({tag, "_busy"},      64'(busy),      64'd0);
   endtask

   // Reference rule: first requester searching upward from last+1 with wrap
   function automatic int rr_pick(input logic [3:0] m, input int last);
      int idx;
      for (int k = 1; k <= 4; k++) begin
         idx = (last + k) % 4;
         if (m[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   task automatic run_txn(input vec_t v);
      int         g, k, waited;
      bit         aw_seen, w_seen, hs_aw, hs_w, hs_b;
      logic [3:0] onehot;
      logic [7:0] exp_bresp;
      g = v.exp_g;
      onehot = 4'b0001 << g;
      for (int i = 0; i < 4; i++) begin
         if (v.mask[i] && !pend_aw[i]) begin
            ra[i] = (i == g) ? v.addr : v.addr ^ (32'(i + 1) << 24);
            rd[i] = (i == g) ? v.data : v.data ^ (32'(i + 1) << 20);
            rs[i] = (i == g) ? 4'hF : 4'($urandom_range(0, 15));
            pend_aw[i] = 1'b1;
            pend_w[i]  = 1'b1;
         end
      end
      drive_reqs();
      #1;
      check("idle_m_awvalid", 64'(m_awvalid), 64'd0);
      waited = 0;
      do begin
         @(posedge clk); @(negedge clk);
         waited++;
      end while (!busy && waited < 5);
      check("grant_latency", 64'(waited), 64'd1);
      check("grant_id", 64'(grant_id), 64'(g));
      if (!busy) return;

      aw_seen = 0; w_seen = 0; k = 0;
      while (!(aw_seen && w_seen) && k < 20) begin
         m_awready = (k >= v.aw_dly);
         m_wready  = (k >= v.w_dly);
         m_bvalid  = 1'($urandom_range(0, 1));
         m_bresp   = 2'($urandom_range(0, 3));
         #1;
         check("xfer_m_awvalid", 64'(m_awvalid), 64'(!aw_seen));
         check("xfer_m_wvalid",  64'(m_wvalid),  64'(!w_seen));
         if (!aw_seen) check("xfer_m_awaddr", 64'(m_awaddr), 64'(ra[g]));
         if (!w_seen) begin
            check("xfer_m_wdata", 64'(m_wdata), 64'(rd[g]));
            check("xfer_m_wstrb", 64'(m_wstrb), 64'(rs[g]));
         end
         check("xfer_s_awready", 64'(s_awready), 64'((!aw_seen && m_awready) ? onehot : 4'b0));
         check("xfer_s_wready",  64'(s_wready),  64'((!w_seen && m_wready) ? onehot : 4'b0));
         check("xfer_m_bready",  64'(m_bready),  64'd0);
         check("xfer_s_bvalid",  64'(s_bvalid),  64'd0);
         check("xfer_s_bresp",   64'(s_bresp),   64'd0);
         check("xfer_busy",      64'(busy),      64'd1);
         hs_aw = m_awvalid && m_awready;
         hs_w  = m_wvalid && m_wready;
         @(posedge clk); @(negedge clk);
         if (hs_aw) begin aw_seen = 1; pend_aw[g] = 1'b0; end
         if (hs_w)  begin w_seen = 1;  pend_w[g]  = 1'b0; end
         drive_reqs();
         k++;
      end
      check("xfer_complete", 64'(aw_seen && w_seen), 64'd1);
      m_awready = 1'b0;
      m_wready  = 1'b0;

      exp_bresp = '0;
      exp_bresp[2*g +: 2] = v.resp;
      k = 0;
      hs_b = 0;
      while (!hs_b && k < 20) begin
         m_bvalid = 1'b1;
         m_bresp  = v.resp;
         hs_b     = (k >= v.b_dly);
         s_bready = (4'($urandom_range(0, 15)) & ~onehot) | (hs_b ? onehot : 4'b0);
         #1;
         check("resp_busy",      64'(busy),      64'd1);
         check("resp_grant_id",  64'(grant_id),  64'(g));
         check("resp_s_bvalid",  64'(s_bvalid),  64'(onehot));
         check("resp_s_bresp",   64'(s_bresp),   64'(exp_bresp));
         check("resp_m_bready",  64'(m_bready),  64'(hs_b));
         check("resp_m_awvalid", 64'(m_awvalid), 64'd0);
         check("resp_m_wvalid",  64'(m_wvalid),  64'd0);
         if (v.rst_mid) begin
            rst = 1'b0;
            #1;
            check_quiet("rst_mid");
            check("rst_mid_grant_id", 64'(grant_id), 64'd0);
            @(posedge clk); @(negedge clk);
            rst = 1'b1;
            pend_aw = '0; pend_w = '0;
            drive_reqs();
            m_bvalid = 1'b0; s_bready = '0;
            model_last = 3;
            return;
         end
         @(posedge clk); @(negedge clk);
         k++;
      end
      m_bvalid = 1'b0;
      s_bready = '0;
      #1;
      check("post_b_busy",     64'(busy),     64'd0);
      check("post_b_grant_id", 64'(grant_id), 64'(g));
      model_last = g;
   endtask

   initial begin
      vec_t rv;
      logic [3:0] m;
      rst = 1'b0;
      s_awvalid = '0; s_wvalid = '0; s_bready = '0;
      s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
      pend_aw = '0; pend_w = '0; model_last = 3;
      for (int i = 0; i < 4; i++) begin ra[i] = '0; rd[i] = '0; rs[i] = '0; end

      tbl[0]  = '{4'b1101, RESP_OKAY,   0, 0, 0, 0, 0, 32'h100, 32'h11111111};
      tbl[1]  = '{4'b1101, RESP_OKAY,   1, 0, 0, 0, 2, 32'h104, 32'h22222222};
      tbl[2]  = '{4'b1101, RESP_OKAY,   0, 1, 0, 0, 3, 32'h108, 32'h33333333};
      tbl[3]  = '{4'b1101, RESP_OKAY,   0, 0, 1, 0, 0, 32'h10C, 32'h44444444};
      tbl[4]  = '{4'b0000, RESP_OKAY,   0, 0, 0, 0, 2, 32'h110, 32'h55555555};
      tbl[5]  = '{4'b0000, RESP_OKAY,   0, 0, 0, 0, 3, 32'h114, 32'h66666666};
      tbl[6]  = '{4'b0010, RESP_OKAY,   0, 0, 0, 0, 1, 32'h10,  32'hA5A5A5A5};
      tbl[7]  = '{4'b0001, RESP_EXOKAY, 0, 2, 1, 0, 0, 32'h200, 32'hDEADBEEF};
      tbl[8]  = '{4'b0100, RESP_OKAY,   3, 0, 0, 0, 2, 32'h204, 32'hCAFEF00D};
      tbl[9]  = '{4'b1000, RESP_SLVERR, 1, 1, 4, 0, 3, 32'h208, 32'h0BADC0DE};
      tbl[10] = '{4'b0011, RESP_DECERR, 0, 0, 0, 0, 0, 32'h20C, 32'h12345678};
      tbl[11] = '{4'b0000, RESP_OKAY,   1, 1, 0, 0, 1, 32'h210, 32'h87654321};
      tbl[12] = '{4'b0100, RESP_OKAY,   0, 0, 0, 1, 2, 32'h300, 32'h0F0F0F0F};
      tbl[13] = '{4'b1001, RESP_OKAY,   0, 0, 0, 0, 0, 32'h304, 32'hF0F0F0F0};
      tbl[14] = '{4'b0000, RESP_OKAY,   0, 0, 0, 0, 3, 32'h308, 32'h5A5A5A5A};

      @(negedge clk);
      check_quiet("reset");
      check("reset_grant_id", 64'(grant_id), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 15; t++) run_txn(tbl[t]);

      // W valid without AW valid must not start a transaction
      ra[1] = 32'h400; rd[1] = 32'h99999999; rs[1] = 4'hF;
      pend_w[1] = 1'b1;
      drive_reqs();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); @(negedge clk);
         check("w_alone_busy",     64'(busy),     64'd0);
         check("w_alone_s_wready", 64'(s_wready), 64'd0);
         check("w_alone_grant_id", 64'(grant_id), 64'd3);
      end
      pend_w[1] = 1'b0;
      drive_reqs();

      for (int r = 0; r < 40; r++) begin
         m = 4'($urandom_range(0, 15));
         if ((pend_aw | m) == 4'b0) m = 4'b0001 << $urandom_range(0, 3);
         rv.mask    = m;
         rv.resp    = 2'($urandom_range(0, 3));
         rv.aw_dly  = $urandom_range(0, 3);
         rv.w_dly   = $urandom_range(0, 3);
         rv.b_dly   = $urandom_range(0, 3);
         rv.rst_mid = 0;
         rv.exp_g   = rr_pick(pend_aw | m, model_last);
         rv.addr    = $urandom;
         rv.data    = $urandom;
         run_txn(rv);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
